// File: rtl/mig_user_arbiter.sv
// mig_user_arbiter
//   Shares one MIG DDR2 user interface (address FIFO, write-data FIFO and
//   read return) between requester A and requester B. One command is admitted
//   at a time. A write is sent as two APPDATA_WIDTH beats (low half first).
//   Reads are tracked in a tag FIFO so that each returning beat pair is routed
//   to the port that issued it.
//
//   Configuration macro: MIG_ARB_STRICT_PRIO_EN
//     defined   - port A always wins a tie (B can starve)
//     undefined - round-robin between the ports (A wins the first tie)
//
//   Ports
//     clk0_tb, sys_rst_n              clock, async active-low reset
//     phy_init_done                   no grant while low
//     a_*/b_* req,cmd,addr,wdata,wmask requester command side (held until gnt)
//     a_gnt, b_gnt                    one-cycle grant pulse
//     a_rd_valid, b_rd_valid, rd_data routed read beats
//     rd_outstanding                  reads issued and not fully returned
//     rd_err                          sticky: read data with no read pending
//     app_af_*, app_wdf_*             MIG address / write-data FIFO writes
//     app_af_afull, app_wdf_afull     MIG FIFO almost-full
//     rd_data_valid, rd_data_fifo_out MIG read return
//
//   state | meaning
//   IDLE  | arbitrate; winner's command issued on the next cycle
//   WR2   | second write beat goes to the write-data FIFO
//   GAP   | idle cycle after a read command (keeps one command per 2 cycles)

module mig_user_arbiter #(
  parameter int APPDATA_WIDTH = 128,
  parameter int ADDR_WIDTH    = 31,
  parameter int TAG_DEPTH     = 16
) (
  input  logic                          clk0_tb,
  input  logic                          sys_rst_n,
  input  logic                          phy_init_done,
  input  logic                          a_req,
  input  logic                          b_req,
  input  logic [2:0]                    a_cmd,
  input  logic [2:0]                    b_cmd,
  input  logic [ADDR_WIDTH-1:0]         a_addr,
  input  logic [ADDR_WIDTH-1:0]         b_addr,
  input  logic [2*APPDATA_WIDTH-1:0]    a_wdata,
  input  logic [2*APPDATA_WIDTH-1:0]    b_wdata,
  input  logic [2*APPDATA_WIDTH/8-1:0]  a_wmask,
  input  logic [2*APPDATA_WIDTH/8-1:0]  b_wmask,
  output logic                          a_gnt,
  output logic                          b_gnt,
  output logic                          a_rd_valid,
  output logic                          b_rd_valid,
  output logic [APPDATA_WIDTH-1:0]      rd_data,
  output logic [$clog2(TAG_DEPTH):0]    rd_outstanding,
  output logic                          rd_err,
  output logic                          app_af_wren,
  output logic [ADDR_WIDTH-1:0]         app_af_addr,
  output logic [2:0]                    app_af_cmd,
  output logic                          app_wdf_wren,
  output logic [APPDATA_WIDTH-1:0]      app_wdf_data,
  output logic [APPDATA_WIDTH/8-1:0]    app_wdf_mask_data,
  input  logic                          app_af_afull,
  input  logic                          app_wdf_afull,
  input  logic                          rd_data_valid,
  input  logic [APPDATA_WIDTH-1:0]      rd_data_fifo_out
);

  localparam int TW = $clog2(TAG_DEPTH);
  localparam int MW = APPDATA_WIDTH / 8;
  localparam logic [2:0]  CMD_WR   = 3'b000;
  localparam logic [2:0]  CMD_RD   = 3'b001;
  localparam logic [TW:0] CNT_FULL = (TW+1)'(TAG_DEPTH);
  localparam logic [TW:0] CNT_ONE  = (TW+1)'(1);
  localparam logic [TW-1:0] PTR_ONE = TW'(1);

  typedef enum logic [1:0] {IDLE, WR2, GAP} state_t;

  state_t state_q, state_d;

  logic                     a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                     af_wren_q, af_wren_d;
  logic [ADDR_WIDTH-1:0]    af_addr_q, af_addr_d;
  logic [2:0]               af_cmd_q, af_cmd_d;
  logic                     wdf_wren_q, wdf_wren_d;
  logic [APPDATA_WIDTH-1:0] wdf_data_q, wdf_data_d;
  logic [MW-1:0]            wdf_mask_q, wdf_mask_d;
  logic [APPDATA_WIDTH-1:0] hi_data_q, hi_data_d;
  logic [MW-1:0]            hi_mask_q, hi_mask_d;
`ifndef MIG_ARB_STRICT_PRIO_EN
  logic                     rr_q, rr_d;   // 1: last grant went to B
`endif

  logic [TAG_DEPTH-1:0]     tag_mem_q;
  logic [TW-1:0]            tag_wr_q, tag_rd_q;
  logic [TW:0]              tag_cnt_q;
  logic                     beat_q;
  logic [APPDATA_WIDTH-1:0] rd_data_q;
  logic                     a_rdv_q, b_rdv_q, rd_err_q;

  logic tag_full, tag_empty, tag_push, tag_push_val, tag_pop, rd_fire, head_b;
  logic a_elig, b_elig, pick_a, pick_b;
  logic [2:0]                 win_cmd;
  logic [ADDR_WIDTH-1:0]      win_addr;
  logic [2*APPDATA_WIDTH-1:0] win_wdata;
  logic [2*MW-1:0]            win_wmask;

  assign tag_full  = (tag_cnt_q == CNT_FULL);
  assign tag_empty = (tag_cnt_q == '0);

  assign a_elig = phy_init_done && a_req && !app_af_afull &&
                  (((a_cmd == CMD_WR) && !app_wdf_afull) || ((a_cmd == CMD_RD) && !tag_full));
  assign b_elig = phy_init_done && b_req && !app_af_afull &&
                  (((b_cmd == CMD_WR) && !app_wdf_afull) || ((b_cmd == CMD_RD) && !tag_full));

`ifdef MIG_ARB_STRICT_PRIO_EN
  assign pick_a = a_elig;
`else
  assign pick_a = a_elig && (!b_elig || rr_q);
`endif
  assign pick_b = b_elig && !pick_a;

  assign win_cmd   = pick_b ? b_cmd   : a_cmd;
  assign win_addr  = pick_b ? b_addr  : a_addr;
  assign win_wdata = pick_b ? b_wdata : a_wdata;
  assign win_wmask = pick_b ? b_wmask : a_wmask;

  always_comb begin
    state_d      = state_q;
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    af_wren_d    = 1'b0;
    af_addr_d    = af_addr_q;
    af_cmd_d     = af_cmd_q;
    wdf_wren_d   = 1'b0;
    wdf_data_d   = wdf_data_q;
    wdf_mask_d   = wdf_mask_q;
    hi_data_d    = hi_data_q;
    hi_mask_d    = hi_mask_q;
    tag_push     = 1'b0;
    tag_push_val = 1'b0;
`ifndef MIG_ARB_STRICT_PRIO_EN
    rr_d         = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_a || pick_b) begin
          a_gnt_d   = pick_a;
          b_gnt_d   = pick_b;
          af_wren_d = 1'b1;
          af_addr_d = win_addr;
          af_cmd_d  = win_cmd;
`ifndef MIG_ARB_STRICT_PRIO_EN
          rr_d      = pick_b;
`endif
          if (win_cmd == CMD_WR) begin
            wdf_wren_d = 1'b1;
            wdf_data_d = win_wdata[APPDATA_WIDTH-1:0];
            wdf_mask_d = win_wmask[MW-1:0];
            // upper half is held here so the requester may move on after gnt
            hi_data_d  = win_wdata[2*APPDATA_WIDTH-1:APPDATA_WIDTH];
            hi_mask_d  = win_wmask[2*MW-1:MW];
            state_d    = WR2;
          end else begin
            tag_push     = 1'b1;
            tag_push_val = pick_b;
            state_d      = GAP;
          end
        end
      end
      // beat1 is sent regardless of afull: MIG afull leaves enough margin
      WR2: begin
        wdf_wren_d = 1'b1;
        wdf_data_d = hi_data_q;
        wdf_mask_d = hi_mask_q;
        state_d    = IDLE;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk0_tb or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      af_wren_q  <= 1'b0;
      af_addr_q  <= '0;
      af_cmd_q   <= '0;
      wdf_wren_q <= 1'b0;
      wdf_data_q <= '0;
      wdf_mask_q <= '0;
      hi_data_q  <= '0;
      hi_mask_q  <= '0;
`ifndef MIG_ARB_STRICT_PRIO_EN
      rr_q       <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      af_wren_q  <= af_wren_d;
      af_addr_q  <= af_addr_d;
      af_cmd_q   <= af_cmd_d;
      wdf_wren_q <= wdf_wren_d;
      wdf_data_q <= wdf_data_d;
      wdf_mask_q <= wdf_mask_d;
      hi_data_q  <= hi_data_d;
      hi_mask_q  <= hi_mask_d;
`ifndef MIG_ARB_STRICT_PRIO_EN
      rr_q       <= rr_d;
`endif
    end
  end

  // Read return: every beat is routed by the head tag; the tag retires on
  // the second beat of its burst.
  assign head_b  = tag_mem_q[tag_rd_q];
  assign rd_fire = rd_data_valid && !tag_empty;
  assign tag_pop = rd_fire && beat_q;

  always_ff @(posedge clk0_tb or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tag_mem_q <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
      beat_q    <= 1'b0;
      rd_data_q <= '0;
      a_rdv_q   <= 1'b0;
      b_rdv_q   <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      a_rdv_q <= rd_fire && !head_b;
      b_rdv_q <= rd_fire && head_b;
      if (rd_fire) begin
        rd_data_q <= rd_data_fifo_out;
        beat_q    <= ~beat_q;
      end
      if (rd_data_valid && tag_empty) rd_err_q <= 1'b1;
      if (tag_push) begin
        tag_mem_q[tag_wr_q] <= tag_push_val;
        tag_wr_q            <= tag_wr_q + PTR_ONE;
      end
      if (tag_pop) tag_rd_q <= tag_rd_q + PTR_ONE;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + CNT_ONE;
        2'b01:   tag_cnt_q <= tag_cnt_q - CNT_ONE;
        default: tag_cnt_q <= tag_cnt_q;
      endcase
    end
  end

  assign a_gnt             = a_gnt_q;
  assign b_gnt             = b_gnt_q;
  assign app_af_wren       = af_wren_q;
  assign app_af_addr       = af_addr_q;
  assign app_af_cmd        = af_cmd_q;
  assign app_wdf_wren      = wdf_wren_q;
  assign app_wdf_data      = wdf_data_q;
  assign app_wdf_mask_data = wdf_mask_q;
  assign a_rd_valid        = a_rdv_q;
  assign b_rd_valid        = b_rdv_q;
  assign rd_data           = rd_data_q;
  assign rd_outstanding    = tag_cnt_q;
  assign rd_err            = rd_err_q;

endmodule

// File: tb/tb_mig_user_arbiter.sv
module tb_mig_user_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         phy, a_req, b_req, af_afull, wdf_afull, rdv;
  logic [2:0]   a_cmd, b_cmd;
  logic [30:0]  a_addr, b_addr;
  logic [255:0] a_wdata, b_wdata;
  logic [31:0]  a_wmask, b_wmask;
  logic [127:0] rdfo;

  logic         a_gnt, b_gnt, a_rd_valid, b_rd_valid, rd_err;
  logic [127:0] rd_data, app_wdf_data;
  logic [4:0]   rd_outstanding;
  logic         app_af_wren, app_wdf_wren;
  logic [30:0]  app_af_addr;
  logic [2:0]   app_af_cmd;
  logic [15:0]  app_wdf_mask_data;

  mig_user_arbiter dut (
    .clk0_tb(clk), .sys_rst_n(rst_n), .phy_init_done(phy),
    .a_req(a_req), .b_req(b_req), .a_cmd(a_cmd), .b_cmd(b_cmd),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_wmask(a_wmask), .b_wmask(b_wmask), .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rd_valid(a_rd_valid), .b_rd_valid(b_rd_valid), .rd_data(rd_data),
    .rd_outstanding(rd_outstanding), .rd_err(rd_err),
    .app_af_wren(app_af_wren), .app_af_addr(app_af_addr), .app_af_cmd(app_af_cmd),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .app_wdf_mask_data(app_wdf_mask_data), .app_af_afull(af_afull),
    .app_wdf_afull(wdf_afull), .rd_data_valid(rdv), .rd_data_fifo_out(rdfo)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: transaction-level view of the arbiter.
  int           busy;      // edges to wait before requests are considered again
  bit           last_b;    // last grant went to B
  bit           b1_pend;
  logic [127:0] b1_data;
  logic [15:0]  b1_mask;
  int           tagq[$];   // issuing port of each outstanding read, oldest first
  bit           half;
  bit           err_m;

  task automatic model_reset();
    busy = 0; last_b = 1'b1; b1_pend = 1'b0; tagq.delete(); half = 1'b0; err_m = 1'b0;
  endtask

  task automatic cycle();
    bit ea, eb, full, ret, exp_w, exp_av, exp_bv;
    int win;
    logic [2:0]   wc;
    logic [30:0]  wa;
    logic [255:0] wd;
    logic [31:0]  wm;
    logic [127:0] rv, exp_wd;
    logic [15:0]  exp_wm;
    full = (tagq.size() >= 16);
    ea = phy && a_req && !af_afull && ((a_cmd == 3'd0 && !wdf_afull) || (a_cmd == 3'd1 && !full));
    eb = phy && b_req && !af_afull && ((b_cmd == 3'd0 && !wdf_afull) || (b_cmd == 3'd1 && !full));
    win = 0;
    if (busy == 0) begin
`ifdef MIG_ARB_STRICT_PRIO_EN
      if (ea) win = 1; else if (eb) win = 2;
`else
      if (ea && eb) win = last_b ? 1 : 2;
      else if (ea) win = 1;
      else if (eb) win = 2;
`endif
    end
    wc = (win == 2) ? b_cmd : a_cmd;
    wa = (win == 2) ? b_addr : a_addr;
    wd = (win == 2) ? b_wdata : a_wdata;
    wm = (win == 2) ? b_wmask : a_wmask;
    ret = rdv;
    rv  = rdfo;
    @(posedge clk); #1;
    chk("a_gnt", a_gnt, win == 1);
    chk("b_gnt", b_gnt, win == 2);
    chk("af_wren", app_af_wren, win != 0);
    if (win != 0) begin
      chk("af_addr", app_af_addr, wa);
      chk("af_cmd", app_af_cmd, wc);
    end
    exp_w = 1'b0; exp_wd = '0; exp_wm = '0;
    if (win != 0 && wc == 3'd0) begin
      exp_w = 1'b1; exp_wd = wd[127:0]; exp_wm = wm[15:0];
    end else if (b1_pend) begin
      exp_w = 1'b1; exp_wd = b1_data; exp_wm = b1_mask;
    end
    chk("wdf_wren", app_wdf_wren, exp_w);
    if (exp_w) begin
      chk("wdf_data", app_wdf_data, exp_wd);
      chk("wdf_mask", app_wdf_mask_data, exp_wm);
    end
    b1_pend = (win != 0 && wc == 3'd0);
    b1_data = wd[255:128];
    b1_mask = wm[31:16];
    if (win != 0) begin
      busy = 1;
      last_b = (win == 2);
    end else if (busy > 0) busy = busy - 1;
    exp_av = 1'b0; exp_bv = 1'b0;
    if (ret) begin
      if (tagq.size() == 0) err_m = 1'b1;
      else begin
        if (tagq[0] == 0) exp_av = 1'b1; else exp_bv = 1'b1;
        if (half) void'(tagq.pop_front());
        half = !half;
      end
    end
    if (win != 0 && wc == 3'd1) tagq.push_back((win == 2) ? 1 : 0);
    chk("a_rd_valid", a_rd_valid, exp_av);
    chk("b_rd_valid", b_rd_valid, exp_bv);
    if (exp_av || exp_bv) chk("rd_data", rd_data, rv);
    chk("rd_outstanding", rd_outstanding, tagq.size());
    chk("rd_err", rd_err, err_m);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_af_wren", app_af_wren, 0);
    chk("rst_af_addr", app_af_addr, 0);
    chk("rst_af_cmd", app_af_cmd, 0);
    chk("rst_wdf_wren", app_wdf_wren, 0);
    chk("rst_wdf_data", app_wdf_data, 0);
    chk("rst_wdf_mask", app_wdf_mask_data, 0);
    chk("rst_rd_valid", {a_rd_valid, b_rd_valid}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_outstanding", rd_outstanding, 0);
    chk("rst_rd_err", rd_err, 0);
    model_reset();
    a_req = 1'b0; b_req = 1'b0; rdv = 1'b0; af_afull = 1'b0; wdf_afull = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input int port, input int maxc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      cycle();
      if ((port == 0) ? a_gnt : b_gnt) got = 1'b1;
    end
    chk("gnt_within_bound", got, 1'b1);
    if (port == 0) a_req = 1'b0; else b_req = 1'b0;
  endtask

  task automatic new_req(input int port);
    logic [2:0] c;
    c = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
    if (port == 0) begin
      a_req = 1'b1; a_cmd = c; a_addr = 31'($urandom);
      a_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      a_wmask = $urandom;
    end else begin
      b_req = 1'b1; b_cmd = c; b_addr = 31'($urandom);
      b_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b_wmask = $urandom;
    end
  endtask

  initial begin
    int cnt, ca, cb;
    logic [127:0] lo, hi;
    phy = 1'b0; a_req = 1'b0; b_req = 1'b0; af_afull = 1'b0; wdf_afull = 1'b0; rdv = 1'b0;
    a_cmd = '0; b_cmd = '0; a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    a_wmask = '0; b_wmask = '0; rdfo = '0;
    model_reset();
    #2;
    do_reset();

    // no grant before phy_init_done, then A first and B two cycles later
    lo = 128'h0123_4567_89ab_cdef_1111_2222_3333_4444;
    hi = 128'hfedc_ba98_7654_3210_aaaa_bbbb_cccc_dddd;
    a_req = 1'b1; a_cmd = 3'd0; a_addr = 31'h100; a_wdata = {hi, lo}; a_wmask = 32'h1234_5678;
    b_req = 1'b1; b_cmd = 3'd0; b_addr = 31'h200; b_wdata = {8{32'h5a5a_0f0f}}; b_wmask = 32'h0;
    repeat (3) begin
      cycle();
      chk("no_gnt_phy_low", {a_gnt, b_gnt, app_af_wren, app_wdf_wren}, 0);
    end
    phy = 1'b1;
    cycle();
    chk("a_first", a_gnt, 1'b1);
    chk("wr_addr_100", app_af_addr, 31'h100);
    chk("wr_beat0_lo", app_wdf_data, lo);
    a_req = 1'b0;
    cycle();
    chk("wr_beat1_hi", app_wdf_data, hi);
    cycle();
    chk("b_two_later", b_gnt, 1'b1);
    b_req = 1'b0;
    cycle(); cycle();

    // a lone write drives the write-data FIFO for exactly two cycles
    a_req = 1'b1; a_cmd = 3'd0; a_addr = 31'h140;
    cnt = 0;
    repeat (6) begin
      cycle();
      if (a_gnt) a_req = 1'b0;
      cnt += int'(app_wdf_wren);
    end
    chk("wdf_wren_cycles", cnt, 2);

    // A read then B read, four beats routed A,A,B,B
    a_req = 1'b1; a_cmd = 3'd1; a_addr = 31'h300;
    wait_gnt(0, 4);
    b_req = 1'b1; b_cmd = 3'd1; b_addr = 31'h380;
    wait_gnt(1, 4);
    chk("two_outstanding", rd_outstanding, 2);
    rdv = 1'b1;
    rdfo = 128'hd0; cycle(); chk("d0_to_a", {a_rd_valid, b_rd_valid}, 2'b10); chk("d0_data", rd_data, 128'hd0); chk("cnt_after_d0", rd_outstanding, 2);
    rdfo = 128'hd1; cycle(); chk("d1_to_a", {a_rd_valid, b_rd_valid}, 2'b10); chk("cnt_after_d1", rd_outstanding, 1);
    rdfo = 128'hd2; cycle(); chk("d2_to_b", {a_rd_valid, b_rd_valid}, 2'b01); chk("d2_data", rd_data, 128'hd2);
    rdfo = 128'hd3; cycle(); chk("d3_to_b", {a_rd_valid, b_rd_valid}, 2'b01); chk("cnt_after_d3", rd_outstanding, 0);
    rdv = 1'b0;
    cycle();

    // tag FIFO full: 17th read blocked, B's write still served
    for (int i = 0; i < 16; i++) begin
      a_req = 1'b1; a_cmd = 3'd1; a_addr = 31'h400 + 31'(i);
      wait_gnt(0, 4);
    end
    chk("sixteen_outstanding", rd_outstanding, 16);
    a_req = 1'b1; a_cmd = 3'd1; a_addr = 31'h500;
    b_req = 1'b1; b_cmd = 3'd0; b_addr = 31'h600;
    wait_gnt(1, 6);
    repeat (6) begin
      cycle();
      chk("read_blocked_full", a_gnt, 1'b0);
    end
    rdv = 1'b1; rdfo = 128'he0; cycle();
    rdfo = 128'he1; cycle();
    rdv = 1'b0;
    wait_gnt(0, 6);
    chk("refilled_outstanding", rd_outstanding, 16);
    do_reset();
    phy = 1'b1;

    // write held by wdf almost-full, read from B still granted; rd_err sticky
    wdf_afull = 1'b1;
    a_req = 1'b1; a_cmd = 3'd0; a_addr = 31'h700;
    b_req = 1'b1; b_cmd = 3'd1; b_addr = 31'h780;
    wait_gnt(1, 4);
    repeat (3) begin
      cycle();
      chk("write_held_afull", a_gnt, 1'b0);
    end
    wdf_afull = 1'b0;
    wait_gnt(0, 4);
    cycle();
    rdv = 1'b1; rdfo = 128'hb0; cycle(); chk("b_read_beat0", b_rd_valid, 1'b1);
    rdfo = 128'hb1; cycle(); chk("b_read_beat1", b_rd_valid, 1'b1);
    rdv = 1'b0; cycle();
    chk("drained", rd_outstanding, 0);
    rdv = 1'b1; rdfo = 128'hbad; cycle();
    rdv = 1'b0;
    chk("rd_err_set", rd_err, 1'b1);
    chk("stray_not_routed", {a_rd_valid, b_rd_valid}, 0);
    repeat (3) begin
      cycle();
      chk("rd_err_sticky", rd_err, 1'b1);
    end
    // reset in the middle of a write burst
    a_req = 1'b1; a_cmd = 3'd0; a_addr = 31'h800;
    wait_gnt(0, 4);
    chk("mid_burst_beat0", app_wdf_wren, 1'b1);
    do_reset();
    phy = 1'b1;

    // both ports requesting continuously
    a_req = 1'b1; a_cmd = 3'd0; a_addr = 31'h900;
    b_req = 1'b1; b_cmd = 3'd0; b_addr = 31'ha00;
    ca = 0; cb = 0;
    repeat (16) begin
      cycle();
      ca += int'(a_gnt);
      cb += int'(b_gnt);
    end
`ifdef MIG_ARB_STRICT_PRIO_EN
    chk("contend_a_count", ca, 8);
    chk("contend_b_count", cb, 0);
`else
    chk("contend_a_count", ca, 4);
    chk("contend_b_count", cb, 4);
`endif
    a_req = 1'b0; b_req = 1'b0;
    cycle(); cycle();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (!a_req || a_gnt || (a_cmd > 3'd1 && $urandom_range(0, 3) == 0)) begin
        if ($urandom_range(0, 1) == 1) new_req(0); else a_req = 1'b0;
      end
      if (!b_req || b_gnt || (b_cmd > 3'd1 && $urandom_range(0, 3) == 0)) begin
        if ($urandom_range(0, 1) == 1) new_req(1); else b_req = 1'b0;
      end
      af_afull  = ($urandom_range(0, 9) == 0);
      wdf_afull = ($urandom_range(0, 9) == 0);
      if (tagq.size() > 0 && (half || $urandom_range(0, 5) == 0)) begin
        rdv = 1'b1;
        rdfo = {$urandom, $urandom, $urandom, $urandom};
      end else rdv = 1'b0;
      cycle();
    end
    a_req = 1'b0; b_req = 1'b0; rdv = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mig_user_arbiter.md
# mig_user_arbiter

Two-port arbiter and sequencer that shares the single MIG DDR2 user interface (address FIFO, write-data FIFO, read-data return) between requester A and requester B in the `clk0_tb` domain. It admits one command at a time, fair or prioritised, and emits write bursts as two `APPDATA_WIDTH` beats. It tracks outstanding reads in a tag FIFO and steers returning read data to the port that issued the read. It sits between user logic and `mig_user`, after `phy_init_done`.

## Interface
- `APPDATA_WIDTH`, 128, MIG user data beat width; one burst (BURST_LEN 4) is 2 beats.
- `ADDR_WIDTH`, 31, width of `app_af_addr`.
- `TAG_DEPTH`, 16, outstanding-read tag FIFO depth (power of 2).
- `clk0_tb` in 1: MIG user clock; all logic rising-edge.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `phy_init_done` in 1: no grant while low.
- `a_req`, `b_req` in 1 each: command request; hold with cmd/addr/data stable until grant.
- `a_cmd`, `b_cmd` in 3 each: 3'b000 write, 3'b001 read; others ignored (never granted).
- `a_addr`, `b_addr` in ADDR_WIDTH each: MIG address.
- `a_wdata`, `b_wdata` in 2*APPDATA_WIDTH each: burst data, beat0 = low half.
- `a_wmask`, `b_wmask` in 2*APPDATA_WIDTH/8 each: burst mask, beat0 = low half.
- `a_gnt`, `b_gnt` out 1 each: one-cycle grant pulse.
- `a_rd_valid`, `b_rd_valid` out 1 each: routed read beat valid.
- `rd_data` out APPDATA_WIDTH: read beat, shared by both ports.
- `rd_outstanding` out log2(TAG_DEPTH)+1: reads issued, not fully returned.
- `rd_err` out 1: sticky; read data arrived with tag FIFO empty.
- `app_af_wren` out 1; `app_af_addr` out ADDR_WIDTH; `app_af_cmd` out 3.
- `app_wdf_wren` out 1; `app_wdf_data` out APPDATA_WIDTH; `app_wdf_mask_data` out APPDATA_WIDTH/8.
- `app_af_afull`, `app_wdf_afull` in 1 each: MIG FIFO almost-full.
- `rd_data_valid` in 1; `rd_data_fifo_out` in APPDATA_WIDTH: MIG read return.

## Operation
- All outputs registered. Reset: every output 0; state IDLE; tag FIFO empty; beat toggle 0; RR pointer = B (A wins first tie); `rd_err` 0.
- Eligibility in IDLE: `phy_init_done`=1 and `req`=1 and valid cmd; write also needs `app_af_afull`=0 and `app_wdf_afull`=0; read also needs `app_af_afull`=0 and tag FIFO not full.
- Arbitration: one eligible → it wins; both eligible → port not granted last; pointer updates on every grant. Ineligible request never blocks the other port.
- States: IDLE, WR2, GAP.
  - IDLE, write win: next cycle `gnt`, `app_af_wren` (cmd 000, addr), `app_wdf_wren` beat0 → WR2.
  - WR2: `app_wdf_wren` beat1 of latched data, `gnt`/`af_wren` low → IDLE.
  - IDLE, read win: next cycle `gnt`, `app_af_wren` (cmd 001); push tag (0=A, 1=B) → GAP.
  - GAP: all strobes low → IDLE.
- Request fields latched on the winning edge; requester may change them after seeing `gnt`.
- Read return: on each `rd_data_valid`, `rd_data` <= `rd_data_fifo_out`, valid of head-tag port set next cycle; beat toggle flips; on second beat tag popped. Push and pop in same cycle allowed; count unchanged.
- `rd_data_valid` with tag FIFO empty: `rd_err` set (cleared only by reset), data dropped, no port valid.
- Almost-full rising during WR2 does not abort beat1 (MIG afull leaves margin).
- Reset mid-burst: everything returns to reset values immediately; partial burst not completed.

## Timing
- Grant latency: req sampled at edge N (IDLE) → `gnt`/`app_af_wren` high in cycle N+1.
- Per-port command rate: max one per 2 cycles; both ports contending alternate A,B,A,B.
- Read data latency through block: 1 cycle from `rd_data_valid` to `x_rd_valid`.
- Read returns in issue order.

## Configuration
- `MIG_ARB_STRICT_PRIO_EN` defined: port A always wins when both eligible; RR pointer unused; B can starve.
- Undefined: round-robin as above.

## Test plan
- Reset, `phy_init_done`=0, both req with writes → no gnt, no strobes; raise `phy_init_done` → `a_gnt` first, then `b_gnt` 2 cycles later.
- A write addr 0x100, wdata {H,L} → `app_af_wren` cmd 000 addr 0x100 with `app_wdf_data`=L, next cycle `app_wdf_data`=H, `app_wdf_wren` exactly 2 cycles.
- A read then B read; MIG returns 4 beats D0..D3 → D0,D1 on `a_rd_valid`, D2,D3 on `b_rd_valid`, `rd_outstanding` 2→1→0.
- Issue 16 reads without return → 17th read not granted while a pending write from B is still granted; one return pair frees a slot → read granted.
- `app_wdf_afull`=1: A write held, B read granted; `rd_data_valid` pulse with no outstanding reads → `rd_err`=1 sticky until `sys_rst_n` low.
- Both continuously request with `MIG_ARB_STRICT_PRIO_EN` defined → only `a_gnt`; undefined → strict alternation.
